// File: rtl/det_matrix_loader_pkg.sv
// -----------------------------------------------------------------------------
// det_matrix_loader_pkg
// Shared definitions for the determinant front-end loader, the ULA wrapper and
// the testbench: element/matrix widths, size codes, loader state encoding and
// a helper that maps a size code to the index of its last element.
// -----------------------------------------------------------------------------
package det_matrix_loader_pkg;

    // Signed element width and largest matrix the bus is dimensioned for.
    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

    // The loader only fills up to 4x4, so 16 byte lanes and a 4-bit index suffice.
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned LOAD_LANES = 16;

    // Size codes shared with the ULA.
    typedef enum logic [1:0] {
        SZ_2X2 = 2'b00,
        SZ_3X3 = 2'b01,
        SZ_4X4 = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EVAL = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Index of the final element for a supported size (N*N-1).
    function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] size);
        logic [IDX_W-1:0] idx;
        unique case (size)
            SZ_2X2:  idx = IDX_W'(3);
            SZ_3X3:  idx = IDX_W'(8);
            default: idx = IDX_W'(15);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/det_matrix_loader_if.sv
// -----------------------------------------------------------------------------
// det_matrix_loader_if
// Groups the loader's host handshake, ULA bus and result signals.
//   master : host/command side (drives start, size_in, in_valid, in_data) plus
//            the ULA return path (det_in, ovf_in); observes everything else.
//   slave  : the loader itself.
// Signals:
//   start, size_in         transaction request and size code
//   in_valid, in_data      element byte stream, in_ready back-pressure
//   matriz, tamanho_matriz packed matrix and size code towards the ULA
//   det_in, ovf_in         ULA determinant and overflow
//   busy, done             transaction status / one-cycle completion pulse
//   result, result_ovf     captured determinant and overflow
//   size_err               last start requested the unsupported size
// -----------------------------------------------------------------------------
interface det_matrix_loader_if;
    import det_matrix_loader_pkg::*;

    logic                     start;
    logic [1:0]               size_in;
    logic                     in_valid;
    logic [ELEM_W-1:0]        in_data;
    logic                     in_ready;
    logic [MAT_W-1:0]         matriz;
    logic [1:0]               tamanho_matriz;
    logic [ELEM_W-1:0]        det_in;
    logic                     ovf_in;
    logic                     busy;
    logic                     done;
    logic [ELEM_W-1:0]        result;
    logic                     result_ovf;
    logic                     size_err;

    modport master (
        output start, size_in, in_valid, in_data, det_in, ovf_in,
        input  in_ready, matriz, tamanho_matriz, busy, done, result, result_ovf, size_err
    );

    modport slave (
        input  start, size_in, in_valid, in_data, det_in, ovf_in,
        output in_ready, matriz, tamanho_matriz, busy, done, result, result_ovf, size_err
    );

endinterface

// File: rtl/det_matrix_loader.sv
// -----------------------------------------------------------------------------
// det_matrix_loader
// Front end of the combinational determinant ULA. A start in IDLE latches the
// size code, then element bytes are accepted one per handshake and packed
// densely (element i at bits [8i+7:8i]) into the registered matrix bus. One
// settle cycle later the ULA's det/overflow are captured and done pulses.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  det_matrix_loader_if.slave (handshake, ULA bus, results)
// -----------------------------------------------------------------------------
module det_matrix_loader
    import det_matrix_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    det_matrix_loader_if.slave  bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        size_q, size_d;
    logic [MAT_W-1:0]  matriz_q, matriz_d;
    logic [ELEM_W-1:0] result_q, result_d;
    logic              result_ovf_q, result_ovf_d;
    logic              size_err_q, size_err_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        size_d       = size_q;
        matriz_d     = matriz_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;
        size_err_d   = size_err_q;

        unique case (state_q)
            ST_IDLE: begin
                // A byte offered together with start is deliberately not consumed.
                if (bus.start) begin
                    if (bus.size_in == SZ_BAD) begin
                        size_err_d = 1'b1;
                        result_d   = '0;
                        state_d    = ST_DONE;
                    end else begin
                        size_d       = bus.size_in;
                        matriz_d     = '0;
                        result_d     = '0;
                        result_ovf_d = 1'b0;
                        size_err_d   = 1'b0;
                        idx_d        = '0;
                        state_d      = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (bus.in_valid) begin
                    // Byte-lane write; lanes above 15 are never addressed and stay 0.
                    for (int i = 0; i < LOAD_LANES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            matriz_d[i*ELEM_W +: ELEM_W] = bus.in_data;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == last_idx(size_q)) begin
                        state_d = ST_EVAL;
                    end
                end
            end

            ST_EVAL: begin
                // matriz has been registered for a full cycle, so the ULA has settled.
                result_d     = bus.det_in;
                result_ovf_d = bus.ovf_in;
                state_d      = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            size_q       <= SZ_2X2;
            matriz_q     <= '0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            size_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            size_q       <= size_d;
            matriz_q     <= matriz_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
            size_err_q   <= size_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: status flags decode straight from the state register.
    // -------------------------------------------------------------------------
    assign bus.in_ready       = (state_q == ST_LOAD);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.matriz         = matriz_q;
    assign bus.tamanho_matriz = size_q;
    assign bus.result         = result_q;
    assign bus.result_ovf     = result_ovf_q;
    assign bus.size_err       = size_err_q;

endmodule
